// File: rtl/cordic_pipe_gen.sv
// Parametrised fully pipelined CORDIC: rotation/vectoring per sample, quadrant
// pre-rotation, optional gain compensation, valid/mode/tag sideband, global stall.
module cordic_pipe_gen #(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 14,
    parameter int GAIN_COMP = 0,
    parameter int TAG_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] q,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    output logic                    out_mode,
    output logic [TAG_W-1:0]        out_tag,
    output logic signed [WIDTH-1:0] cosq,
    output logic signed [WIDTH-1:0] sinq,
    output logic signed [WIDTH-1:0] qout
);
    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam int FZ = WIDTH - 3;
    localparam int HALF_PI_I = $rtoi(1.5707963267948966 * (2.0 ** FZ) + 0.5);
    localparam logic signed [ZW-1:0] HALF_PI = ZW'(HALF_PI_I);
    localparam logic signed [ZW-1:0] NEG_HALF_PI = -HALF_PI;

    function automatic logic [31:0] atan_q30(input int i);
        case (i)
            0:  return 32'h3243F6A9;
            1:  return 32'h1DAC6705;
            2:  return 32'h0FADBAFD;
            3:  return 32'h07F56EA7;
            4:  return 32'h03FEAB77;
            5:  return 32'h01FFD55C;
            6:  return 32'h00FFFAAB;
            7:  return 32'h007FFF55;
            8:  return 32'h003FFFEB;
            9:  return 32'h001FFFFD;
            10: return 32'h00100000;
            11: return 32'h00080000;
            12: return 32'h00040000;
            13: return 32'h00020000;
            14: return 32'h00010000;
            15: return 32'h00008000;
            16: return 32'h00004000;
            17: return 32'h00002000;
            18: return 32'h00001000;
            19: return 32'h00000800;
            20: return 32'h00000400;
            21: return 32'h00000200;
            22: return 32'h00000100;
            23: return 32'h00000080;
            default: return 32'h0;
        endcase
    endfunction

    // Q2.30 table entry rounded half-up into the internal z format
    function automatic logic signed [ZW-1:0] atan_z(input int i);
        longint a;
        a = longint'(atan_q30(i));
        if (FZ < 30)
            a = (a + (64'sd1 <<< (29 - FZ))) >>> (30 - FZ);
        else
            a = a <<< (FZ - 30);
        return a[ZW-1:0];
    endfunction

    logic signed [XW-1:0] xr [0:STAGES];
    logic signed [XW-1:0] yr [0:STAGES];
    logic signed [ZW-1:0] zr [0:STAGES];
    logic                 vr [0:STAGES];
    logic                 mr [0:STAGES];
    logic [TAG_W-1:0]     tr [0:STAGES];

    logic signed [XW-1:0] xn [0:STAGES-1];
    logic signed [XW-1:0] yn [0:STAGES-1];
    logic signed [ZW-1:0] zn [0:STAGES-1];

    logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre;
    logic signed [ZW-1:0] q_ext, z_pre;

    assign x_ext = {{2{x[WIDTH-1]}}, x};
    assign y_ext = {{2{y[WIDTH-1]}}, y};
    assign q_ext = {q[WIDTH-1], q};

    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = q_ext;
        unique case (1'b1)
            !mode && (q_ext > HALF_PI): begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = q_ext - HALF_PI;
            end
            !mode && (q_ext < NEG_HALF_PI): begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = q_ext + HALF_PI;
            end
            mode && x_ext[XW-1] && !y_ext[XW-1]: begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = q_ext + HALF_PI;
            end
            mode && x_ext[XW-1] && y_ext[XW-1]: begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = q_ext - HALF_PI;
            end
            default: ;
        endcase
    end

    // d = +1 when z >= 0 (rotation) or y < 0 (vectoring)
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            if (mr[i] ? yr[i][XW-1] : !zr[i][ZW-1]) begin
                xn[i] = xr[i] - (yr[i] >>> i);
                yn[i] = yr[i] + (xr[i] >>> i);
                zn[i] = zr[i] - atan_z(i);
            end else begin
                xn[i] = xr[i] + (yr[i] >>> i);
                yn[i] = yr[i] - (xr[i] >>> i);
                zn[i] = zr[i] + atan_z(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                xr[k] <= '0;
                yr[k] <= '0;
                zr[k] <= '0;
                vr[k] <= 1'b0;
                mr[k] <= 1'b0;
                tr[k] <= '0;
            end
        end else if (en) begin
            xr[0] <= x_pre;
            yr[0] <= y_pre;
            zr[0] <= z_pre;
            vr[0] <= in_valid;
            mr[0] <= mode;
            tr[0] <= in_tag;
            for (int k = 0; k < STAGES; k++) begin
                xr[k+1] <= xn[k];
                yr[k+1] <= yn[k];
                zr[k+1] <= zn[k];
                vr[k+1] <= vr[k];
                mr[k+1] <= mr[k];
                tr[k+1] <= tr[k];
            end
        end
    end

    logic signed [XW-1:0] xf, yf;
    logic signed [ZW-1:0] zf;
    logic                 vf, mf;
    logic [TAG_W-1:0]     tf;

    if (GAIN_COMP != 0) begin : g_gain
        localparam int PW = XW + WIDTH;
        localparam int KC_I = $rtoi(0.6072529 * (2.0 ** (WIDTH - 2)) + 0.5);
        localparam logic signed [PW-1:0] KC = PW'(KC_I);
        localparam logic signed [PW-1:0] RND = PW'(1) <<< (WIDTH - 3);
        logic signed [PW-1:0] px, py;

        assign px = PW'(xr[STAGES]) * KC + RND;
        assign py = PW'(yr[STAGES]) * KC + RND;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                xf <= '0;
                yf <= '0;
                zf <= '0;
                vf <= 1'b0;
                mf <= 1'b0;
                tf <= '0;
            end else if (en) begin
                xf <= XW'(px >>> (WIDTH - 2));
                yf <= XW'(py >>> (WIDTH - 2));
                zf <= zr[STAGES];
                vf <= vr[STAGES];
                mf <= mr[STAGES];
                tf <= tr[STAGES];
            end
        end
    end else begin : g_raw
        assign xf = xr[STAGES];
        assign yf = yr[STAGES];
        assign zf = zr[STAGES];
        assign vf = vr[STAGES];
        assign mf = mr[STAGES];
        assign tf = tr[STAGES];
    end

    // clamp to the output range whenever the guard bits disagree with the sign
    assign cosq = (xf[XW-1:WIDTH-1] == {3{xf[XW-1]}}) ? xf[WIDTH-1:0]
                : {xf[XW-1], {(WIDTH-1){~xf[XW-1]}}};
    assign sinq = (yf[XW-1:WIDTH-1] == {3{yf[XW-1]}}) ? yf[WIDTH-1:0]
                : {yf[XW-1], {(WIDTH-1){~yf[XW-1]}}};
    assign qout = (zf[ZW-1:WIDTH-1] == {2{zf[ZW-1]}}) ? zf[WIDTH-1:0]
                : {zf[ZW-1], {(WIDTH-1){~zf[ZW-1]}}};

    assign out_valid = vf;
    assign out_mode  = mf;
    assign out_tag   = tf;
endmodule

// File: tb/tb_cordic_pipe_gen.sv
// Directed bench for cordic_pipe_gen: raw-gain and gain-compensated instances
// driven in parallel, hand-computed expected values with an LSB tolerance.
module tb_cordic_pipe_gen;
    localparam int ST = 14;

    logic clk = 1'b0;
    logic reset, en, in_valid, mode;
    logic signed [15:0] x, y, q;
    logic [3:0] in_tag;

    logic out_valid, out_mode;
    logic [3:0] out_tag;
    logic signed [15:0] cosq, sinq, qout;

    logic g_valid, g_mode;
    logic [3:0] g_tag;
    logic signed [15:0] g_cos, g_sin, g_q;

    int n_checks = 0;
    int n_fail = 0;

    logic signed [15:0] res_c, res_s, res_q, gr_c, gr_s, gr_q;
    logic [3:0] res_tag;
    logic res_mode;

    typedef struct {
        logic [3:0] tag;
        logic m;
        int e0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cordic_pipe_gen #(.WIDTH(16), .STAGES(ST), .GAIN_COMP(0), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .mode(mode),
        .x(x), .y(y), .q(q), .in_tag(in_tag),
        .out_valid(out_valid), .out_mode(out_mode), .out_tag(out_tag),
        .cosq(cosq), .sinq(sinq), .qout(qout)
    );

    cordic_pipe_gen #(.WIDTH(16), .STAGES(ST), .GAIN_COMP(1), .TAG_W(4)) dut_g (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .mode(mode),
        .x(x), .y(y), .q(q), .in_tag(in_tag),
        .out_valid(g_valid), .out_mode(g_mode), .out_tag(g_tag),
        .cosq(g_cos), .sinq(g_sin), .qout(g_q)
    );

    task automatic check(input string tag, input int got, input int want,
                         input int tol = 0);
        int d;
        n_checks++;
        d = got - want;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic m, input logic [15:0] vx,
                           input logic [15:0] vy, input logic [15:0] vq,
                           input logic [3:0] tg);
        int n0, n1;
        n0 = 0;
        n1 = 0;
        mode = m;
        x = vx;
        y = vy;
        q = vq;
        in_tag = tg;
        in_valid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            in_valid = 1'b0;
            if (n0 == 0 && out_valid) begin
                n0 = n;
                res_c = cosq;
                res_s = sinq;
                res_q = qout;
                res_tag = out_tag;
                res_mode = out_mode;
            end
            if (n1 == 0 && g_valid) begin
                n1 = n;
                gr_c = g_cos;
                gr_s = g_sin;
                gr_q = g_q;
            end
            if (n0 != 0 && n1 != 0) break;
        end
        check("lat_raw", n0, ST + 1);
        check("lat_gain", n1, ST + 2);
        check("vec_tag", res_tag, tg);
        check("vec_mode", res_mode, m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale, ecnt, sent, got;
        logic en_c, last_v;
        logic [3:0] last_tag;
        exp_t e;

        reset = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        mode = 1'b0;
        x = '0;
        y = '0;
        q = '0;
        in_tag = '0;
        #2 reset = 1'b0;
        repeat (3) tick;
        check("rst_valid", out_valid, 0);
        check("rst_cos", cosq, 0);
        check("rst_sin", sinq, 0);
        check("rst_q", qout, 0);
        check("rst_tag", out_tag, 0);
        check("rst_mode", out_mode, 0);
        check("rst_gvalid", g_valid, 0);
        reset = 1'b1;
        tick;

        run_vec(1'b0, 16'h26DD, 16'h0000, 16'h1922, 4'h1);
        check("rot45_cos", res_c, 11585, 8);
        check("rot45_sin", res_s, 11585, 8);
        check("rot45_q", res_q, 0, 8);

        run_vec(1'b0, 16'h26DD, 16'h0000, 16'h4000, 4'h2);
        check("rot2_cos", res_c, -6818, 8);
        check("rot2_sin", res_s, 14898, 8);
        check("rot2_q", res_q, 0, 8);

        run_vec(1'b0, 16'h26DD, 16'h0000, 16'hC000, 4'h3);
        check("rotm2_cos", res_c, -6818, 8);
        check("rotm2_sin", res_s, -14898, 8);

        run_vec(1'b0, 16'h26DD, 16'h0000, 16'h3244, 4'h4);
        check("rot90_cos", res_c, 0, 8);
        check("rot90_sin", res_s, 16384, 8);

        run_vec(1'b0, 16'h26DD, 16'h0000, 16'h9B78, 4'h5);
        check("rotmpi_cos", res_c, -16384, 8);
        check("rotmpi_sin", res_s, 0, 8);

        run_vec(1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 4'h6);
        check("satp_cos", res_c, 32767);
        check("satp_sin", res_s, 32767);

        run_vec(1'b0, 16'h8000, 16'h8000, 16'h0000, 4'h7);
        check("satn_cos", res_c, -32768);
        check("satn_sin", res_s, -32768);

        run_vec(1'b1, 16'h2000, 16'h2000, 16'h0000, 4'h8);
        check("vec45_gcos", gr_c, 11585, 8);
        check("vec45_gsin", gr_s, 0, 8);
        check("vec45_gq", gr_q, 6434, 8);
        check("vec45_cos", res_c, 19078, 8);
        check("vec45_q", res_q, 6434, 8);

        run_vec(1'b1, 16'hE000, 16'h0000, 16'h0000, 4'h9);
        check("vecpi_gcos", gr_c, 8192, 8);
        check("vecpi_gq", gr_q, 25736, 8);

        run_vec(1'b1, 16'hE000, 16'hE000, 16'h0000, 4'hA);
        check("vecq3_gcos", gr_c, 11585, 8);
        check("vecq3_gq", gr_q, -19302, 8);

        run_vec(1'b1, 16'h0000, 16'h0000, 16'h1000, 4'hB);
        check("vec0_gcos", gr_c, 0);
        check("vec0_gsin", gr_s, 0);
        check("vec0_cos", res_c, 0);
        check("vec0_sin", res_s, 0);

        // reset pulse between edges while results are streaming out
        for (int i = 0; i < 18; i++) begin
            mode = 1'b0;
            x = 16'h26DD;
            y = 16'h0000;
            q = 16'h1922;
            in_tag = i[3:0];
            in_valid = 1'b1;
            tick;
        end
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_cos", cosq, 11585, 8);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cos", cosq, 0);
        check("mid_rst_sin", sinq, 0);
        check("mid_rst_q", qout, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_gvalid", g_valid, 0);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (out_valid || g_valid) stale++;
        end
        check("no_stale", stale, 0);

        // mixed-mode stream with a 4-cycle stall, then en toggling
        ecnt = 0;
        sent = 0;
        got = 0;
        last_v = 1'b0;
        last_tag = '0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            en_c = (c < 8) ? 1'b1 : (c < 12) ? 1'b0 : ((c % 2) == 0);
            en = en_c;
            if (en_c && sent < 20) begin
                mode = sent[0];
                in_tag = sent[3:0];
                x = sent[0] ? 16'h2000 : 16'h26DD;
                y = sent[0] ? 16'h2000 : 16'h0000;
                q = sent[0] ? 16'h0000 : 16'h1922;
                in_valid = 1'b1;
                sb.push_back('{sent[3:0], sent[0], ecnt});
                sent++;
            end else if (!en_c) begin
                mode = 1'b1;
                in_tag = 4'hF;
                x = 16'h7FFF;
                y = 16'h1234;
                q = 16'h4321;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (en_c) begin
                ecnt++;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("stream_extra", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("stream_tag", out_tag, e.tag);
                        check("stream_mode", out_mode, e.m);
                        check("stream_lat", ecnt - e.e0, ST + 1);
                        check("stream_cos", cosq, e.m ? 19078 : 11585, 8);
                        got++;
                        last_tag = e.tag;
                    end
                    last_v = 1'b1;
                end else begin
                    last_v = 1'b0;
                end
            end else begin
                check("hold_valid", out_valid, last_v);
                if (last_v) check("hold_tag", out_tag, last_tag);
            end
        end
        en = 1'b1;
        in_valid = 1'b0;
        check("stream_count", got, 20);
        check("stream_left", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
